// File: rtl/bounce_motion_engine.sv
// Motion core for the bouncing-logo screensaver: steps the logo position once
// per frame tick, reflects it off the screen edges, cycles colour and counts corners.
module bounce_motion_engine #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int LOGO_W     = 64,
  parameter int LOGO_H     = 32,
  parameter int COORD_W    = 10,
  parameter int SPEED_W    = 3,
  parameter int NUM_COLORS = 8,
  parameter int CNT_W      = 8,
  parameter int X0         = 0,
  parameter int Y0         = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 enable,
  input  logic                 pause,
  input  logic [SPEED_W-1:0]   speed,
  input  logic                 load_valid,
  input  logic [COORD_W-1:0]   load_x,
  input  logic [COORD_W-1:0]   load_y,
  output logic [COORD_W-1:0]   pos_x,
  output logic [COORD_W-1:0]   pos_y,
  output logic                 dir_x,
  output logic                 dir_y,
  output logic [((NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1)-1:0] color_idx,
  output logic                 bounce,
  output logic                 corner_hit,
  output logic [CNT_W-1:0]     corner_count
);

  localparam int CIDX_W = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;
  localparam int XMAX_I = SCREEN_W - LOGO_W;
  localparam int YMAX_I = SCREEN_H - LOGO_H;
  localparam logic [COORD_W:0]   XMAX     = XMAX_I[COORD_W:0];
  localparam logic [COORD_W:0]   YMAX     = YMAX_I[COORD_W:0];
  localparam logic [COORD_W-1:0] X_RST    = X0[COORD_W-1:0];
  localparam logic [COORD_W-1:0] Y_RST    = Y0[COORD_W-1:0];
  localparam logic [CIDX_W-1:0]  CIDX_TOP = CIDX_W'(NUM_COLORS - 1);

  logic              do_step;
  logic              do_load;
  logic [COORD_W:0]  spd;
  logic [COORD_W:0]  ext_x, ext_y;
  logic [COORD_W:0]  sum_x, sum_y;
  logic [COORD_W:0]  dif_x, dif_y;
  logic [COORD_W-1:0] nxt_x, nxt_y;
  logic              nxt_dx, nxt_dy;
  logic              hit_x, hit_y;
  logic [COORD_W-1:0] ld_x, ld_y;
  logic [CIDX_W-1:0] color_nxt;

  // A load takes priority over a coincident tick; enable gates both.
  assign do_load = load_valid & enable;
  assign do_step = frame_tick & enable & ~pause & ~load_valid;

  // One extra bit of headroom so pos+speed and pos-speed never wrap.
  assign spd   = {{(COORD_W + 1 - SPEED_W){1'b0}}, speed};
  assign ext_x = {1'b0, pos_x};
  assign ext_y = {1'b0, pos_y};
  assign sum_x = ext_x + spd;
  assign sum_y = ext_y + spd;
  assign dif_x = ext_x - spd;
  assign dif_y = ext_y - spd;

  always_comb begin
    nxt_x  = pos_x;
    nxt_dx = dir_x;
    hit_x  = 1'b0;
    if (spd != '0) begin
      if (dir_x) begin
        if (sum_x >= XMAX) begin
          nxt_x  = XMAX[COORD_W-1:0];
          nxt_dx = 1'b0;
          hit_x  = 1'b1;
        end else begin
          nxt_x = sum_x[COORD_W-1:0];
        end
      end else if (ext_x <= spd) begin
        nxt_x  = '0;
        nxt_dx = 1'b1;
        hit_x  = 1'b1;
      end else begin
        nxt_x = dif_x[COORD_W-1:0];
      end
    end
  end

  always_comb begin
    nxt_y  = pos_y;
    nxt_dy = dir_y;
    hit_y  = 1'b0;
    if (spd != '0) begin
      if (dir_y) begin
        if (sum_y >= YMAX) begin
          nxt_y  = YMAX[COORD_W-1:0];
          nxt_dy = 1'b0;
          hit_y  = 1'b1;
        end else begin
          nxt_y = sum_y[COORD_W-1:0];
        end
      end else if (ext_y <= spd) begin
        nxt_y  = '0;
        nxt_dy = 1'b1;
        hit_y  = 1'b1;
      end else begin
        nxt_y = dif_y[COORD_W-1:0];
      end
    end
  end

  assign ld_x      = ({1'b0, load_x} > XMAX) ? XMAX[COORD_W-1:0] : load_x;
  assign ld_y      = ({1'b0, load_y} > YMAX) ? YMAX[COORD_W-1:0] : load_y;
  assign color_nxt = (color_idx == CIDX_TOP) ? '0 : color_idx + CIDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x        <= X_RST;
      pos_y        <= Y_RST;
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      color_idx    <= '0;
      bounce       <= 1'b0;
      corner_hit   <= 1'b0;
      corner_count <= '0;
    end else begin
      bounce     <= 1'b0;
      corner_hit <= 1'b0;
      if (do_load) begin
        pos_x <= ld_x;
        pos_y <= ld_y;
      end else if (do_step) begin
        pos_x      <= nxt_x;
        pos_y      <= nxt_y;
        dir_x      <= nxt_dx;
        dir_y      <= nxt_dy;
        bounce     <= hit_x | hit_y;
        corner_hit <= hit_x & hit_y;
        if (hit_x | hit_y) color_idx <= color_nxt;
        if (hit_x & hit_y & ~&corner_count) corner_count <= corner_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/bounce_motion_engine.md
Name: bounce_motion_engine

Overview:
- Parametrised motion core for the bouncing-logo screensaver.
- Holds the logo's top-left position and direction, and advances it once per frame tick by a programmable step.
- Reflects the logo off all four screen edges, cycles a colour index on every bounce, and detects and counts exact corner hits.
- Sits between the VGA timing generator (source of frame_tick) and the pixel/sprite renderer (consumer of pos_x/pos_y/color_idx).

Parameters:
- SCREEN_W, 640, active screen width in pixels
- SCREEN_H, 480, active screen height in pixels
- LOGO_W, 64, logo width in pixels
- LOGO_H, 32, logo height in pixels
- COORD_W, 10, width of position outputs and load inputs
- SPEED_W, 3, width of step input
- NUM_COLORS, 8, colour palette size; color_idx wraps modulo this
- CNT_W, 8, corner counter width
- X0, 0, reset x position
- Y0, 0, reset y position

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- frame_tick, input, 1, one-cycle pulse at start of vertical blanking
- enable, input, 1, motion enable; 0 freezes all state
- pause, input, 1, freezes motion; load still accepted
- speed, input, SPEED_W, pixels moved per tick on each axis; 0 means no motion
- load_valid, input, 1, one-cycle request to reposition the logo
- load_x, input, COORD_W, requested x position
- load_y, input, COORD_W, requested y position
- pos_x, output, COORD_W, current logo left edge
- pos_y, output, COORD_W, current logo top edge
- dir_x, output, 1, 1 = moving right
- dir_y, output, 1, 1 = moving down
- color_idx, output, clog2(NUM_COLORS), current palette index
- bounce, output, 1, one-cycle pulse when any edge is hit
- corner_hit, output, 1, one-cycle pulse when both axes bounce on the same tick
- corner_count, output, CNT_W, saturating count of corner hits

Behaviour:
- Reset values: pos_x=X0, pos_y=Y0, dir_x=1, dir_y=1, color_idx=0, bounce=0, corner_hit=0, corner_count=0.
- Limits: XMAX = SCREEN_W-LOGO_W, YMAX = SCREEN_H-LOGO_H. X0 must be ≤ XMAX and Y0 ≤ YMAX.
- Step condition: frame_tick & enable & ~pause & ~load_valid. All updates are registered, so outputs change on the clock edge after the qualifying tick cycle (latency 1).
- Per-axis update, x shown; y is identical with YMAX:
  - dir_x=1 and pos_x+speed ≥ XMAX → pos_x=XMAX, dir_x=0, x-bounce.
  - dir_x=0 and pos_x ≤ speed → pos_x=0, dir_x=1, x-bounce.
  - Otherwise pos_x ± speed.
  - Arithmetic is done at COORD_W+1 bits so no wrap-around occurs.
- speed=0: no position change and no bounce, even when sitting on an edge.
- bounce=1 for exactly one cycle if the x- or y-axis bounced. color_idx advances by exactly 1 (mod NUM_COLORS) per bounce tick, even if both axes bounced.
- corner_hit=1 for one cycle when both axes bounce on the same tick. corner_count then increments and saturates at all-ones.
- Load:
  - load_valid sets pos_x=min(load_x, XMAX) and pos_y=min(load_y, YMAX).
  - Directions, color_idx and counter are unchanged; no bounce is generated.
  - load_valid on the same cycle as frame_tick: load wins and the step is skipped.
  - load is honoured while pause=1 and ignored while enable=0.
- enable=0: all registers hold; the bounce and corner_hit pulses are forced to 0.
- Asynchronous reset mid-motion returns all outputs to reset values immediately. A frame_tick arriving while rst_n=0 is lost.
- Back-to-back frame_tick on consecutive cycles is legal; each one is a separate step.

Test Plan:
- Reset with X0=0, Y0=0, speed=4: 10 ticks → pos=(40,40), dir=(1,1), bounce never asserted.
- Right edge: load (574,100), dir_x=1, speed=4, one tick → pos_x=576 (XMAX), dir_x=0, bounce pulses for 1 cycle, color_idx 0→1.
- Exact corner: load (572,444), speed=4, one tick → pos=(576,448), corner_hit=1, corner_count=1, color_idx advances by exactly 1.
- Pause and speed zero: pause=1 across 5 ticks → position frozen; then load (1000,1000) → pos=(576,448) clamped. With speed=0 at an edge, a tick produces no bounce.
- Tick and load in the same cycle, load=(10,20) → pos=(10,20) with no step applied. Reset asserted mid-run → outputs return to X0/Y0 asynchronously, before the next clock edge.
- Counter saturation with CNT_W=2: force 5 corner hits → corner_count stays at 3.
